// File: rtl/vga_frame_adapter.sv
// vga_frame_adapter: pixel-plot receiver and VGA scan-out engine.
//   Plot writes (VGA_X, VGA_Y, VGA_COLOR, plot) land in an on-chip frame
//   buffer of COLS x ROWS words of 3*CB bits. The buffer is continuously
//   scanned out as 640x480 @ 60 Hz VGA, each stored pixel replicated SxS
//   with S = 640/COLS.
// Optional feature: define VGA_CLEAR_EN to add a clear engine that fills the
//   buffer with BG_COLOR after every reset (busy=1 while it runs).
// Ports:
//   CLOCK_50, Resetn         50 MHz clock, synchronous active-low reset
//   VGA_X, VGA_Y, VGA_COLOR  plot coordinate and 24-bit {R,G,B} color
//   plot                     write strobe, one write per clock
//   busy                     clear engine owns the buffer
//   VGA_R/G/B                8-bit DAC color, zero outside visible region
//   VGA_HS, VGA_VS           active-low syncs
//   VGA_BLANK_N              high in visible region
//   VGA_SYNC_N               constant 0
//   VGA_CLK                  25 MHz pixel clock to the DAC
module vga_frame_adapter #(
    parameter int unsigned nX   = 8,
    parameter int unsigned nY   = 7,
    parameter int unsigned COLS = 160,
    parameter int unsigned ROWS = 120,
    parameter int unsigned Mn   = 15,
    parameter int unsigned CB   = 4
`ifdef VGA_CLEAR_EN
    ,
    parameter logic [23:0] BG_COLOR = 24'h000000
`endif
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic [nX-1:0] VGA_X,
    input  logic [nY-1:0] VGA_Y,
    input  logic [23:0]   VGA_COLOR,
    input  logic          plot,
    output logic          busy,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic          VGA_CLK
);

    localparam int unsigned SCALE    = 640 / COLS;
    localparam int unsigned SH       = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);
    localparam int unsigned WORDS    = COLS * ROWS;
    localparam int unsigned DW       = 3 * CB;
    localparam int unsigned CW       = 10;
    localparam int unsigned H_VIS    = 640;
    localparam int unsigned H_SYNC_S = 656;
    localparam int unsigned H_SYNC_E = 752;
    localparam int unsigned H_TOT    = 800;
    localparam int unsigned V_VIS    = 480;
    localparam int unsigned V_SYNC_S = 490;
    localparam int unsigned V_SYNC_E = 492;
    localparam int unsigned V_TOT    = 525;

    // Keep the CB most significant bits of each 8-bit channel.
    function automatic logic [DW-1:0] pack_color(input logic [23:0] c);
        return {c[23 -: CB], c[15 -: CB], c[7 -: CB]};
    endfunction

    // Widen a CB-bit field to 8 bits by repeating it MSB-first.
    function automatic logic [7:0] expand(input logic [CB-1:0] f);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = f[CB-1-(i%CB)];
        end
        return e;
    endfunction

    logic [DW-1:0] mem [WORDS];
    logic [DW-1:0] rd_data;
    logic [Mn-1:0] rd_addr;
    logic          wr_en;
    logic [Mn-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic          pix_en;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          h_vis, v_vis, hs_now, vs_now;
    logic          s1_hs, s1_vs, s1_vis;

    logic          plot_ok;
    logic          unused_color_bits;

    assign unused_color_bits = ^VGA_COLOR;
    assign VGA_SYNC_N        = 1'b0;

    // In-range plot request; the write itself is gated further below.
    assign plot_ok = plot && (32'(VGA_X) < COLS) && (32'(VGA_Y) < ROWS);

`ifdef VGA_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state, state_nxt;
    logic [Mn-1:0] clr_addr, clr_addr_nxt;

    // Clear engine state register; busy follows the next state.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
            busy     <= (state_nxt == CLEAR);
        end
    end

    // Clear engine next state and buffer write port mux.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        wr_en        = 1'b0;
        wr_addr      = Mn'(32'(VGA_Y) * COLS + 32'(VGA_X));
        wr_data      = pack_color(VGA_COLOR);
        case (state)
            CLEAR: begin
                wr_en        = Resetn;
                wr_addr      = clr_addr;
                wr_data      = pack_color(BG_COLOR);
                clr_addr_nxt = clr_addr + Mn'(1);
                if (clr_addr == Mn'(WORDS - 1)) begin
                    state_nxt    = IDLE;
                    clr_addr_nxt = '0;
                end
            end
            IDLE: begin
                wr_en = Resetn && plot_ok;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
`else
    assign busy    = 1'b0;
    assign wr_en   = Resetn && plot_ok;
    assign wr_addr = Mn'(32'(VGA_Y) * COLS + 32'(VGA_X));
    assign wr_data = pack_color(VGA_COLOR);
`endif

    // Scan position decode and buffer read address (row/col by shift).
    always_comb begin
        h_vis   = (hcount < CW'(H_VIS));
        v_vis   = (vcount < CW'(V_VIS));
        hs_now  = !((hcount >= CW'(H_SYNC_S)) && (hcount < CW'(H_SYNC_E)));
        vs_now  = !((vcount >= CW'(V_SYNC_S)) && (vcount < CW'(V_SYNC_E)));
        rd_addr = Mn'(32'(vcount >> SH) * COLS + 32'(hcount >> SH));
    end

    // Frame buffer: read-during-write to one address returns the old word.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (pix_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Pixel clock, scan counters and the two-tick output pipeline.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            pix_en      <= 1'b0;
            VGA_CLK     <= 1'b1;
            hcount      <= '0;
            vcount      <= '0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            s1_vis      <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            pix_en  <= ~pix_en;
            VGA_CLK <= ~pix_en;
            if (pix_en) begin
                if (hcount == CW'(H_TOT - 1)) begin
                    hcount <= '0;
                    vcount <= (vcount == CW'(V_TOT - 1)) ? '0 : vcount + CW'(1);
                end else begin
                    hcount <= hcount + CW'(1);
                end
                s1_hs       <= hs_now;
                s1_vs       <= vs_now;
                s1_vis      <= h_vis && v_vis;
                VGA_HS      <= s1_hs;
                VGA_VS      <= s1_vs;
                VGA_BLANK_N <= s1_vis;
                VGA_R       <= s1_vis ? expand(rd_data[DW-1 -: CB])   : 8'h00;
                VGA_G       <= s1_vis ? expand(rd_data[2*CB-1 -: CB]) : 8'h00;
                VGA_B       <= s1_vis ? expand(rd_data[CB-1:0])       : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_adapter.sv
// Bench for vga_frame_adapter (default build). Random plots are mirrored in a
// colour-per-pixel model; expected scan output is computed from the elapsed
// clock count since reset using the 800x525 raster arithmetic.
module tb_vga_frame_adapter;

    logic        CLOCK_50 = 1'b0;
    logic        Resetn   = 1'b0;
    logic [7:0]  VGA_X    = '0;
    logic [6:0]  VGA_Y    = '0;
    logic [23:0] VGA_COLOR = '0;
    logic        plot     = 1'b0;
    logic        busy;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

    vga_frame_adapter dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .VGA_COLOR  (VGA_COLOR),
        .plot       (plot),
        .busy       (busy),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N (VGA_SYNC_N),
        .VGA_CLK    (VGA_CLK)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n         = 0;
    bit          mon_en    = 1'b0;
    bit          check_rgb = 1'b0;
    logic [23:0] fb_model [19200];
    bit          fb_valid [19200];

    // Clock edges since the last reset edge.
    always @(posedge CLOCK_50) n <= Resetn ? n + 1 : 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at n=%0d: got %h, expected %h", tag, n, got, exp);
        end
    endtask

    // Displayed colour: top 4 bits of each channel, replicated (x*17).
    function automatic logic [23:0] shade(input logic [23:0] c);
        int r, g, b;
        r = int'(c[23:16]) / 16;
        g = int'(c[15:8]) / 16;
        b = int'(c[7:0]) / 16;
        return {8'(r * 17), 8'(g * 17), 8'(b * 17)};
    endfunction

    // Output reference: after edge n the outputs show raster position (n-4)/2.
    always @(negedge CLOCK_50) begin
        int p, h, v, idx;
        logic exp_clk, exp_hs, exp_vs, exp_blank, do_rgb;
        logic [23:0] exp_rgb;
        if (mon_en) begin
            exp_clk = !(n >= 2 && (n % 2) == 0);
            exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0;
            exp_rgb = '0; do_rgb = 1'b1;
            if (n >= 4) begin
                p = ((n - 4) / 2) % 420000;
                h = p % 800;
                v = p / 800;
                exp_hs    = !(h >= 656 && h < 752);
                exp_vs    = !(v >= 490 && v < 492);
                exp_blank = (h < 640) && (v < 480);
                if (exp_blank) begin
                    idx     = (v / 4) * 160 + h / 4;
                    do_rgb  = check_rgb && fb_valid[idx];
                    exp_rgb = shade(fb_model[idx]);
                end
            end
            check("ctl", 32'({VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, busy}),
                  32'({exp_clk, exp_hs, exp_vs, exp_blank, 1'b0, 1'b0}));
            if (do_rgb) check("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_rgb));
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic do_plot(input int x, input int y, input logic [23:0] c);
        VGA_X = 8'(x);
        VGA_Y = 7'(y);
        VGA_COLOR = c;
        plot = 1'b1;
        if (x < 160 && y < 120) begin
            fb_model[y * 160 + x] = c;
            fb_valid[y * 160 + x] = 1'b1;
        end
        tick();
        plot = 1'b0;
    endtask

    initial begin
        int row, x;
        // Reset held for three clocks; reset values checked on the last two.
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        Resetn = 1'b1;

        // Fill buffer rows 0..9 back-to-back with random colours.
        for (int y = 0; y < 10; y++) begin
            for (int xx = 0; xx < 160; xx++) begin
                if (y == 0 && xx == 0)       do_plot(xx, y, 24'hFF0000);
                else if (y == 5 && xx == 159) do_plot(xx, y, 24'h12AB3F);
                else                          do_plot(xx, y, 24'($urandom));
            end
        end

        // Out-of-range plots must be dropped (x>=160 would alias into the next row).
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) do_plot(160 + int'($urandom_range(0, 95)), int'($urandom_range(0, 9)), 24'hFFFFFF);
            else            do_plot(int'($urandom_range(0, 255)), 120 + int'($urandom_range(0, 7)), 24'hFFFFFF);
        end

        // One-clock reset mid-line (hcount 300, vcount 1); buffer must survive.
        for (int k = 0; k < 5000 && n != 2200; k++) tick();
        check("align", 32'(n), 32'd2200);
        Resetn = 1'b0;
        check_rgb = 1'b1;
        tick();
        Resetn = 1'b1;

        // Scan 40 lines, with occasional plots a few rows ahead of the beam.
        for (int i = 0; i < 64010; i++) begin
            if (i % 500 == 250) begin
                row = ((n / 2) / 800) / 4 + 2 + int'($urandom_range(0, 1));
                x = int'($urandom_range(0, 159));
                if (row <= 8) begin
                    if ($urandom_range(0, 3) == 0) do_plot(160 + x % 96, row, 24'hFFFFFF);
                    else                           do_plot(x, row, 24'($urandom));
                end else begin
                    tick();
                end
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
